// File: rtl/fib_sram_seq.sv
// Fills a single-port SRAM with the first 2^ADDR_WIDTH Fibonacci terms (mod 2^DATA_WIDTH),
// then serves single-word read-back requests through the same SRAM port.
module fib_sram_seq #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  table_valid,
  output logic                  overflow,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] K_LAST      = (ADDR_WIDTH+1)'(N - 1);
  // a+b computed at index k is term k+2; only sums that will still be written count as overflow
  localparam logic [ADDR_WIDTH:0] K_SUM_LIMIT = (ADDR_WIDTH+1)'(N - 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH:0]   r_k;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_overflow;
  logic                  r_table_valid;
  logic                  r_done;
  logic                  r_rd_valid;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_gen_start;
  logic                  w_rd_accept;
  logic                  w_gen_last;

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_gen_start = (r_state == IDLE) && start;
  assign w_rd_accept = (r_state == IDLE) && !start && rd_req;
  assign w_gen_last  = (r_state == GEN) && (r_k == K_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    sram_we      = 1'b0;
    sram_oe      = 1'b0;
    sram_addr    = '0;
    sram_din     = '0;
    case (r_state)
      IDLE: begin
        if (w_gen_start) begin
          w_state_next = GEN;
        end else if (w_rd_accept) begin
          w_state_next = RD_ISSUE;
        end
      end
      GEN: begin
        sram_we   = 1'b1;
        sram_addr = r_k[ADDR_WIDTH-1:0];
        sram_din  = r_a;
        if (r_k == K_LAST) begin
          w_state_next = IDLE;
        end
      end
      RD_ISSUE: begin
        sram_oe      = 1'b1;
        sram_addr    = r_rd_addr;
        w_state_next = RD_WAIT;
      end
      // The rd_valid pulse is registered and overlaps the return to IDLE,
      // so a follow-on request is accepted in the same cycle data is presented.
      RD_WAIT: w_state_next = IDLE;
      RD_DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k           <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_rd_addr     <= '0;
      r_rd_data     <= '0;
      r_overflow    <= 1'b0;
      r_table_valid <= 1'b0;
      r_done        <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_done     <= w_gen_last;
      r_rd_valid <= (r_state == RD_WAIT);
      if (w_gen_start) begin
        r_k           <= '0;
        r_a           <= '0;
        r_b           <= DATA_WIDTH'(1);
        r_overflow    <= 1'b0;
        r_table_valid <= 1'b0;
      end
      if (w_rd_accept) begin
        r_rd_addr <= rd_addr;
      end
      if (r_state == GEN) begin
        r_a <= r_b;
        r_b <= w_sum[DATA_WIDTH-1:0];
        r_k <= r_k + 1'b1;
        if (w_sum[DATA_WIDTH] && (r_k < K_SUM_LIMIT)) begin
          r_overflow <= 1'b1;
        end
        if (w_gen_last) begin
          r_table_valid <= 1'b1;
        end
      end
      if (r_state == RD_WAIT) begin
        r_rd_data <= sram_dout;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign rd_ready    = (r_state == IDLE);
  assign done        = r_done;
  assign table_valid = r_table_valid;
  assign overflow    = r_overflow;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;

endmodule
